// File: rtl/id_redirect_if.sv
// id_redirect_if: fetch-redirect bundle between the decode resolver and its environment
interface id_redirect_if #(parameter int CNT_W = 16);
  logic [31:0] Instruction_if, NextPC_if, rs_data, rt_data;
  logic ex_RegWrite, ex_MemRead, mem_MemRead;
  logic [4:0] ex_WriteReg, mem_WriteReg;
  logic [31:0] Instruction_id, NextPC_id, BranchAddr, JumpAddr, JrAddr;
  logic [4:0] rs_addr, rt_addr;
  logic Z, J, JR, PC_IFWrite, ID_bubble;
  logic [CNT_W-1:0] stall_count;
  modport master (
    input Instruction_if, NextPC_if, rs_data, rt_data, ex_RegWrite, ex_MemRead, mem_MemRead,
          ex_WriteReg, mem_WriteReg,
    output Instruction_id, NextPC_id, BranchAddr, JumpAddr, JrAddr, rs_addr, rt_addr,
           Z, J, JR, PC_IFWrite, ID_bubble, stall_count
  );
  modport slave (
    output Instruction_if, NextPC_if, rs_data, rt_data, ex_RegWrite, ex_MemRead, mem_MemRead,
           ex_WriteReg, mem_WriteReg,
    input Instruction_id, NextPC_id, BranchAddr, JumpAddr, JrAddr, rs_addr, rt_addr,
          Z, J, JR, PC_IFWrite, ID_bubble, stall_count
  );
endinterface

// File: rtl/id_redirect.sv
// id_redirect: decode-stage branch/jump resolver with hazard stall and IF/ID flush
module id_redirect #(
  parameter logic [31:0] NOP = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset_n,
  id_redirect_if.master bus
);
  logic [31:0] ins, npc;
  logic [CNT_W-1:0] cnt;
  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  logic beq, bne, jmp, jr, ctl, use_rt, ex_hit, mem_hit, stall, eq, z, redirect;
  assign op = ins[31:26];
  assign funct = ins[5:0];
  assign rs = ins[25:21];
  assign rt = ins[20:16];
  assign beq = op == 6'b000100;
  assign bne = op == 6'b000101;
  assign jmp = op == 6'b000010 || op == 6'b000011;
  assign jr = op == 6'b000000 && funct == 6'b001000;
  assign ctl = beq | bne | jr;
  assign use_rt = !jr;
  // register 0 is never a hazard source
  assign ex_hit = bus.ex_WriteReg != 5'd0 && (bus.ex_WriteReg == rs || (use_rt && bus.ex_WriteReg == rt));
  assign mem_hit = bus.mem_WriteReg != 5'd0 && (bus.mem_WriteReg == rs || (use_rt && bus.mem_WriteReg == rt));
  assign stall = (bus.ex_MemRead & ex_hit) | (ctl & bus.ex_RegWrite & ex_hit) | (ctl & bus.mem_MemRead & mem_hit);
  assign eq = bus.rs_data == bus.rt_data;
  // opcodes are mutually exclusive, so {JR,J,Z} stays one-hot or zero
  assign z = !stall & ((beq & eq) | (bne & !eq));
  assign redirect = z | bus.J | bus.JR;
  assign bus.Z = z;
  assign bus.J = !stall & jmp;
  assign bus.JR = !stall & jr;
  assign bus.PC_IFWrite = !stall;
  assign bus.ID_bubble = stall;
  assign bus.Instruction_id = ins;
  assign bus.NextPC_id = npc;
  assign bus.rs_addr = rs;
  assign bus.rt_addr = rt;
  assign bus.BranchAddr = npc + {{14{ins[15]}}, ins[15:0], 2'b00};
  assign bus.JumpAddr = {npc[31:28], ins[25:0], 2'b00};
  assign bus.JrAddr = bus.rs_data;
  assign bus.stall_count = cnt;
  // IF/ID register: hold on stall, flush the wrong-path fetch on redirect, else advance
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ins <= NOP;
      npc <= '0;
    end else if (!stall) begin
      ins <= redirect ? NOP : bus.Instruction_if;
      npc <= bus.NextPC_if;
    end
  // saturating stall-cycle counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (stall && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: tb/tb_id_redirect.sv
// tb_id_redirect: scoreboard bench for the decode-stage redirect resolver
module tb_id_redirect;
  logic clk = 0;
  logic reset_n;
  id_redirect_if #(.CNT_W(16)) bus ();
  id_redirect #(.NOP(32'h0), .CNT_W(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string name;
    logic [31:0] ins, npc;
    logic [2:0] zjr;
    logic pcw, bub;
    logic [15:0] cnt;
    logic [1:0] asel;
    logic [31:0] addr;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  event probe;
  function automatic logic [31:0] r_add(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] br(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(string name, logic [31:0] ins, logic [31:0] npc, logic [2:0] zjr, logic pcw,
                      logic bub, logic [15:0] cnt, logic [1:0] asel, logic [31:0] addr);
    exp_t e;
    e.name = name; e.ins = ins; e.npc = npc; e.zjr = zjr; e.pcw = pcw;
    e.bub = bub; e.cnt = cnt; e.asel = asel; e.addr = addr;
    q.push_back(e);
  endtask
  task automatic drv(logic [31:0] ins, logic [31:0] npc);
    bus.Instruction_if = ins;
    bus.NextPC_if = npc;
  endtask
  initial begin
    exp_t e;
    logic [31:0] ga;
    forever begin
      @(negedge clk or probe);
      if (!$onehot0({bus.JR, bus.J, bus.Z})) begin
        miscompares++;
        $display("FAIL onehot: {JR,J,Z}=%b required one-hot or zero", {bus.JR, bus.J, bus.Z});
      end
      while (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        ga = e.asel == 2'd1 ? bus.BranchAddr : e.asel == 2'd2 ? bus.JumpAddr : e.asel == 2'd3 ? bus.JrAddr : 32'h0;
        if (bus.Instruction_id !== e.ins || bus.NextPC_id !== e.npc || {bus.JR, bus.J, bus.Z} !== e.zjr ||
            bus.PC_IFWrite !== e.pcw || bus.ID_bubble !== e.bub || bus.stall_count !== e.cnt || ga !== e.addr) begin
          miscompares++;
          $display("FAIL %s: got ins=%h npc=%h jjz=%b pcw=%b bub=%b cnt=%h addr=%h; want ins=%h npc=%h jjz=%b pcw=%b bub=%b cnt=%h addr=%h",
                   e.name, bus.Instruction_id, bus.NextPC_id, {bus.JR, bus.J, bus.Z}, bus.PC_IFWrite, bus.ID_bubble,
                   bus.stall_count, ga, e.ins, e.npc, e.zjr, e.pcw, e.bub, e.cnt, e.addr);
        end
      end
    end
  end
  initial begin
    logic [31:0] a1, a2, a3, a8, beq_i, beq9, bne9, j_i, jr_i;
    a1 = r_add(5'd1, 5'd2, 5'd3);
    a2 = r_add(5'd3, 5'd0, 5'd0);
    a3 = r_add(5'd5, 5'd6, 5'd7);
    a8 = r_add(5'd1, 5'd2, 5'd8);
    beq_i = br(6'b000100, 5'd4, 5'd5, 16'hFFFE);
    beq9 = br(6'b000100, 5'd9, 5'd10, 16'h0004);
    bne9 = br(6'b000101, 5'd9, 5'd10, 16'h0000);
    j_i = {6'b000010, 26'h000_0040};
    jr_i = {6'd0, 5'd7, 15'd0, 6'b001000};
    reset_n = 0;
    bus.rs_data = 0; bus.rt_data = 0;
    bus.ex_RegWrite = 0; bus.ex_MemRead = 0; bus.ex_WriteReg = 0;
    bus.mem_MemRead = 0; bus.mem_WriteReg = 0;
    drv(a1, 32'd4);
    tick; push("reset", 32'h0, 32'h0, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0);
    tick; reset_n = 1;
    tick; push("stream1", a1, 32'd4, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0); drv(a2, 32'd8);
    tick; push("stream2", a2, 32'd8, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0); drv(a3, 32'd12);
    tick; push("stream3", a3, 32'd12, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0); drv(beq_i, 32'h10);
    tick; bus.rs_data = 5; bus.rt_data = 5; drv(a1, 32'h14);
    push("beq_taken", beq_i, 32'h10, 3'b001, 1, 0, 16'h0, 2'd1, 32'h8);
    tick; push("beq_flush", 32'h0, 32'h14, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0); drv(beq_i, 32'h10);
    tick; bus.rt_data = 6; drv(a2, 32'h14);
    push("beq_not_taken", beq_i, 32'h10, 3'b000, 1, 0, 16'h0, 2'd1, 32'h8);
    tick; push("beq_no_flush", a2, 32'h14, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0); drv(j_i, 32'h1000_0004);
    tick; drv(a1, 32'h20); push("jump", j_i, 32'h1000_0004, 3'b010, 1, 0, 16'h0, 2'd2, 32'h1000_0100);
    tick; push("jump_flush", 32'h0, 32'h20, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0); drv(jr_i, 32'h24);
    tick; bus.rs_data = 32'h2000; drv(a1, 32'h28);
    push("jr", jr_i, 32'h24, 3'b100, 1, 0, 16'h0, 2'd3, 32'h2000);
    tick; push("jr_flush", 32'h0, 32'h28, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0); drv(a8, 32'h30);
    tick; bus.ex_MemRead = 1; bus.ex_WriteReg = 8; drv(a2, 32'h34);
    push("load_use", a8, 32'h30, 3'b000, 0, 1, 16'h0, 2'd0, 32'h0);
    tick; bus.ex_MemRead = 0; bus.ex_WriteReg = 0;
    push("load_use_release", a8, 32'h30, 3'b000, 1, 0, 16'h1, 2'd0, 32'h0);
    tick; bus.ex_MemRead = 1; bus.ex_WriteReg = 0; drv(beq9, 32'h40);
    push("wreg_zero", a2, 32'h34, 3'b000, 1, 0, 16'h1, 2'd0, 32'h0);
    tick; bus.ex_RegWrite = 1; bus.ex_WriteReg = 9; bus.rs_data = 3; bus.rt_data = 3; drv(a1, 32'h44);
    push("br_load_ex", beq9, 32'h40, 3'b000, 0, 1, 16'h1, 2'd0, 32'h0);
    tick; bus.ex_MemRead = 0; bus.ex_RegWrite = 0; bus.ex_WriteReg = 0; bus.mem_MemRead = 1; bus.mem_WriteReg = 9;
    push("br_load_mem", beq9, 32'h40, 3'b000, 0, 1, 16'h2, 2'd0, 32'h0);
    tick; bus.mem_MemRead = 0; bus.mem_WriteReg = 0;
    push("br_load_go", beq9, 32'h40, 3'b001, 1, 0, 16'h3, 2'd1, 32'h50);
    tick; push("br_load_flush", 32'h0, 32'h44, 3'b000, 1, 0, 16'h3, 2'd0, 32'h0); drv(beq9, 32'h40);
    tick; bus.ex_RegWrite = 1; bus.ex_WriteReg = 10; bus.rt_data = 4; drv(bne9, 32'h60);
    push("br_alu_stall", beq9, 32'h40, 3'b000, 0, 1, 16'h3, 2'd0, 32'h0);
    tick; bus.ex_RegWrite = 0; bus.ex_WriteReg = 0;
    push("br_alu_go", beq9, 32'h40, 3'b000, 1, 0, 16'h4, 2'd1, 32'h50);
    tick; drv(a1, 32'h64); push("bne_taken", bne9, 32'h60, 3'b001, 1, 0, 16'h4, 2'd1, 32'h60);
    tick; push("bne_flush", 32'h0, 32'h64, 3'b000, 1, 0, 16'h4, 2'd0, 32'h0); drv(a8, 32'h70);
    tick; bus.ex_MemRead = 1; bus.ex_WriteReg = 8;
    push("long_stall", a8, 32'h70, 3'b000, 0, 1, 16'h4, 2'd0, 32'h0);
    repeat (65539) tick;
    push("saturate", a8, 32'h70, 3'b000, 0, 1, 16'hFFFF, 2'd0, 32'h0);
    @(negedge clk);
    #1 reset_n = 0;
    #1 push("reset_mid_stall", 32'h0, 32'h0, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0);
    -> probe;
    tick; reset_n = 1; bus.ex_MemRead = 0; bus.ex_WriteReg = 0;
    push("post_reset_nop", 32'h0, 32'h0, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0);
    tick; push("post_reset_load", a8, 32'h70, 3'b000, 1, 0, 16'h0, 2'd0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_redirect.md
Name: id_redirect

Overview:
- Decode-stage control-flow resolver: the producer side of the fetch-redirect interface that the IF stage consumes.
- Holds the IF/ID pipeline register and decodes beq/bne/j/jal/jr from it.
- Drives the one-hot redirect select {JR,J,Z}, the three target addresses, and PC_IFWrite (stall).
- Detects data hazards against the EX and MEM stages; inserts bubbles and flushes the wrong-path instruction.

Parameters:
- NOP, 32'h0000_0000, instruction word loaded into IF/ID on flush.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- Instruction_if  input  32  fetched instruction from IF
- NextPC_if  input  32  PC+4 from IF
- rs_data  input  32  register-file read port A (combinational, addr = rs_addr)
- rt_data  input  32  register-file read port B (addr = rt_addr)
- ex_RegWrite  input  1  instruction in EX writes a register
- ex_MemRead  input  1  instruction in EX is a load
- ex_WriteReg  input  5  destination of the EX instruction
- mem_MemRead  input  1  instruction in MEM is a load
- mem_WriteReg  input  5  destination of the MEM instruction
- Instruction_id  output  32  IF/ID instruction register
- NextPC_id  output  32  IF/ID PC+4 register
- rs_addr  output  5  Instruction_id[25:21]
- rt_addr  output  5  Instruction_id[20:16]
- Z  output  1  take branch (select BranchAddr)
- J  output  1  take jump (select JumpAddr)
- JR  output  1  take register jump (select JrAddr)
- BranchAddr  output  32  branch target
- JumpAddr  output  32  jump target
- JrAddr  output  32  register jump target
- PC_IFWrite  output  1  1 = PC may advance; 0 = stall
- ID_bubble  output  1  1 = ID/EX must load a NOP this cycle
- stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset_n=0, async): Instruction_id=NOP, NextPC_id=0, stall_count=0. All combinational outputs then evaluate to Z=J=JR=0, PC_IFWrite=1, ID_bubble=0.
- IF/ID update, each posedge, in priority order:
  - stall: hold both registers.
  - else redirect (Z|J|JR): load NOP and NextPC_if (flushes the wrong-path fetch).
  - else load Instruction_if and NextPC_if.
- Decode on op=Instruction_id[31:26]:
  - beq = 000100; bne = 000101.
  - j = 000010; jal = 000011 (treated as j; link handled downstream).
  - jr = op 000000 with funct[5:0] = 001000.
- Targets, all mod 2^32, combinational from IF/ID:
  - BranchAddr = NextPC_id + sign_extend(imm16) << 2.
  - JumpAddr = {NextPC_id[31:28], instr[25:0], 2'b00}.
  - JrAddr = rs_data.
- Source usage:
  - beq/bne use rs and rt; jr uses rs only.
  - All other instructions use rs and rt for the load-use check only.
  - Register 0 never matches.
- Stall (combinational) = any of:
  - (a) ex_MemRead and ex_WriteReg != 0 and ex_WriteReg matches a used source.
  - (b) the ID instruction is beq/bne/jr, ex_RegWrite=1, and ex_WriteReg != 0 matches a used source.
  - (c) the ID instruction is beq/bne/jr, mem_MemRead=1, and mem_WriteReg != 0 matches a used source.
- While stall=1: PC_IFWrite=0, ID_bubble=1, Z=J=JR=0.
- While stall=0: PC_IFWrite=1, ID_bubble=0.
  - Z = (beq & rs_data==rt_data) | (bne & rs_data!=rt_data).
  - J = j|jal; JR = jr.
- {JR,J,Z} is one-hot or all-zero in every cycle. The IF stage maps any other code to PC 0, so this is a hard invariant.
- Latency:
  - Resolution is zero-cycle from IF/ID contents.
  - Exactly one wrong-path instruction is flushed per taken redirect.
  - Stall cycles: load-use = 1; branch after ALU op = 1; branch after load = 2 (first via (a), then via (c)).
- stall_count increments on every stall cycle and saturates at all-ones (no wrap).
- Reset asserted mid-stall or mid-flush clears everything immediately; the first cycle after release behaves as NOP in ID.

Test Plan:
1. Reset release, stream of non-branch words (NextPC_if 4,8,12) -> each appears in Instruction_id one cycle later; Z=J=JR=0; PC_IFWrite=1.
2. beq imm=16'hFFFE, NextPC_id=0x0000_0010, rs_data=rt_data=5, no hazards -> Z=1, BranchAddr=0x0000_0008; next edge Instruction_id=NOP. Same case with rt_data=6 -> Z=0, no flush.
3. j target=26'h000_0040, NextPC_id=0x1000_0004 -> J=1, JumpAddr=0x1000_0100. jr with rs_data=0x0000_2000 -> JR=1, JrAddr=0x2000. One-hot assertion holds throughout.
4. Load-use: ex_MemRead=1, ex_WriteReg=8, ID add uses rt=8 -> PC_IFWrite=0 and ID_bubble=1 for one cycle; Instruction_id held; stall_count +1. ex_WriteReg=0 -> no stall.
5. beq on r9 after a load to r9 (EX then MEM) -> 2 stall cycles with Z=0; Z asserted on the third cycle; stall_count +2.
6. Force stall_count to saturate (2^16+3 stall cycles) -> holds 16'hFFFF. Assert reset_n=0 mid-stall -> immediate clear of IF/ID registers and stall_count; PC_IFWrite=1.
